// File: rtl/cordic_phase_acc.sv
// Phase accumulator front end for a CORDIC rotator: integrates a frequency word,
// adds a phase offset, rounds to the rotator angle width and aligns amplitude.
module cordic_phase_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 7,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync,
  input  logic [ACC_WIDTH-1:0]  fcw,
  input  logic                  fcw_valid,
  input  logic [ACC_WIDTH-1:0]  pcw,
  input  logic                  pcw_valid,
  input  logic [DATA_WIDTH-1:0] amp,
  output logic [DATA_WIDTH-1:0] r,
  output logic [ITERATIONS:0]   theta,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int TW    = ITERATIONS + 1;
  localparam int SHIFT = ACC_WIDTH - TW;
  // Half of one theta LSB, expressed in accumulator units.
  localparam logic [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (SHIFT - 1);

  logic [ACC_WIDTH-1:0]  acc;
  logic                  carry;
  logic [ACC_WIDTH-1:0]  fcw_reg;
  logic [ACC_WIDTH-1:0]  pcw_reg;
  logic                  v1;
  logic [DATA_WIDTH-1:0] a1;

  logic [ACC_WIDTH:0]    acc_sum;
  logic [ACC_WIDTH-1:0]  phase;

  assign acc_sum = {1'b0, acc} + {1'b0, fcw_reg};
  // Offset and rounding bias wrap modulo one turn, so phases just below the top round to 0.
  assign phase   = acc + pcw_reg + RND;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_reg <= '0;
      pcw_reg <= '0;
    end else begin
      if (fcw_valid) fcw_reg <= fcw;
      if (pcw_valid) pcw_reg <= pcw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
      v1    <= 1'b0;
      a1    <= '0;
    end else begin
      v1 <= en;
      a1 <= amp;
      if (sync) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (en) begin
        acc   <= acc_sum[ACC_WIDTH-1:0];
        carry <= acc_sum[ACC_WIDTH];
      end
    end
  end

  // theta and r only advance with a valid sample so they hold between outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta     <= '0;
      r         <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= v1;
      wrap      <= carry & v1;
      if (v1) begin
        theta <= TW'(phase >> SHIFT);
        r     <= a1;
      end
    end
  end

endmodule
